rpn_evaluator: RTL and testbench
================================

RPN_EVALUATOR -- requirements
Module: rpn_evaluator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result data width.
REQ-002 SHALL have parameter MAX_DEPTH, default 100, meaning capacity of the attached operand stack.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous and active-low.
REQ-005 SHALL have tok_valid input 1 and tok_ready output 1, token handshake; a token transfers when both are high at a clk edge.
REQ-006 SHALL have tok_is_op input 1 (1 = operator, 0 = operand) and tok_data input WIDTH (operand value or ASCII operator code).
REQ-007 SHALL have stack-side outputs stk_data_in WIDTH, stk_push_en 1, stk_pop_en 1.
REQ-008 SHALL have stack-side inputs stk_data_out WIDTH (combinational top of stack) and stk_empty 1.
REQ-009 SHALL have outputs result WIDTH, result_err 1, result_valid 1 (one-cycle pulse), and depth 8 bits (current stack occupancy).

Function
REQ-010 SHALL implement an FSM with states IDLE, POP_B, POP_A, PUSH_R, POP_RES, DRAIN, DONE; tok_ready SHALL be 1 only in IDLE.
REQ-011 In IDLE, an accepted operand SHALL assert stk_push_en with stk_data_in = tok_data in the same cycle and increment depth; the FSM stays in IDLE.
REQ-012 An accepted operand when depth == MAX_DEPTH SHALL NOT push and SHALL set the error flag, then go to DRAIN.
REQ-013 Operator codes: '+' 0x2B, '-' 0x2D, '*' 0x2A, '=' 0x3D; any other code SHALL set error and go to DRAIN.
REQ-014 An accepted arithmetic operator SHALL latch the opcode and go to POP_B.
REQ-015 POP_B: if stk_empty, set error and go to DRAIN; else latch b = stk_data_out, assert stk_pop_en, go to POP_A.
REQ-016 POP_A: if stk_empty, set error and go to DRAIN; else latch a = stk_data_out, assert stk_pop_en, go to PUSH_R.
REQ-017 PUSH_R: SHALL push op(a, b) and go to IDLE; tok_ready returns 4 cycles after the operator was accepted.
REQ-018 Arithmetic SHALL be unsigned modulo 2^WIDTH: a+b, a-b (a = deeper operand), and the low WIDTH bits of a*b.
REQ-019 Every pop SHALL decrement depth and every push SHALL increment it; PUSH_R leaves the net depth at the pre-operator value minus 1.
REQ-020 An accepted '=' SHALL go to POP_RES. If stk_empty, set error; else latch the result from stk_data_out and pop. Then go to DRAIN.
REQ-021 DRAIN: while !stk_empty, pop each cycle; any pop in DRAIN that follows POP_RES SHALL set error (leftover operands). When stk_empty, go to DONE.
REQ-022 DONE: result_valid = 1 for exactly one cycle, result_err = error flag, result = 0 if error; clear the error flag; go to IDLE. result and result_err SHALL hold until the next DONE.
REQ-023 stk_push_en and stk_pop_en SHALL never both be 1 in the same cycle.
REQ-024 Tokens following an error SHALL be evaluated as a new expression after DONE.

Reset
REQ-025 When rst = 0 at a clk edge: state = IDLE, depth = 0, result = 0, result_err = 0, result_valid = 0, error flag and a/b/opcode latches = 0; a reset mid-operation SHALL abort with no further push or pop.
REQ-026 The stack SHALL be reset in the same cycle by the integrating top level, with rst inverted for the active-high stack.

Configuration
REQ-027 Macro RPN_DIV_EN defined: '/' 0x2F SHALL compute unsigned a/b (truncating); b == 0 SHALL set error, push nothing, and go to DRAIN.
REQ-028 Macro RPN_DIV_EN undefined: no divider SHALL be synthesised, and '/' SHALL be treated as an unknown operator per REQ-013.

Structure
REQ-029 Package rpn_pkg SHALL hold the operator code constants and the FSM state encoding.
REQ-030 The combinational arithmetic SHALL be sub-module rpn_alu (inputs a, b, opcode; outputs y, div_zero).

Verification
REQ-031 Input 3, 4, '+', '=' -> result_valid with result 0x07, result_err 0, and depth 0 afterwards.
REQ-032 Input 5, 9, '-', '=' -> result 0xFC, no error; input 20, 13, '*', '=' -> result 0x04.
REQ-033 Input 7, '+' -> error at POP_A; DRAIN pops the 7; result_valid with result_err 1 and result 0x00.
REQ-034 Input 1, 2, '=' -> result_err 1 after DRAIN pops the leftover operand; input '#' 0x23 -> result_err 1.
REQ-035 Push MAX_DEPTH+1 operands -> the final push is suppressed, error is set, the stack drains to empty, and result_err 1.
REQ-036 Assert rst = 0 during PUSH_R -> no push occurs; the next cycle has state IDLE, depth 0, and tok_ready 1. With RPN_DIV_EN defined, input 9, 0, '/', '=' -> result_err 1.

Source files
------------

// File: rtl/rpn_pkg.sv
// rpn_pkg: shared definitions for the RPN expression evaluator.
//
// Contents:
//   OP_*          ASCII operator codes accepted on the token stream
//   state_t       evaluator FSM state encoding
//   is_arith_op() true for codes that pop two operands and push one result
//
// Configuration macro: RPN_DIV_EN adds '/' to the arithmetic operator set.
package rpn_pkg;

    localparam logic [7:0] OP_ADD = 8'h2B;   // '+'
    localparam logic [7:0] OP_SUB = 8'h2D;   // '-'
    localparam logic [7:0] OP_MUL = 8'h2A;   // '*'
    localparam logic [7:0] OP_DIV = 8'h2F;   // '/'
    localparam logic [7:0] OP_EQ  = 8'h3D;   // '='

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP_B   = 3'd1,
        POP_A   = 3'd2,
        PUSH_R  = 3'd3,
        POP_RES = 3'd4,
        DRAIN   = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Division only counts as a known operator when the divider is built,
    // so a build without it rejects '/' like any other unknown code.
    function automatic logic is_arith_op(input logic [7:0] code);
        logic hit;
        hit = (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
`ifdef RPN_DIV_EN
        hit = hit || (code == OP_DIV);
`endif
        return hit;
    endfunction

endpackage

// File: rtl/rpn_if.sv
// rpn_if: token stream handshake into the RPN evaluator.
//
// Signals:
//   tok_valid  source has a token
//   tok_ready  evaluator can take a token (transfer when both high at clk)
//   tok_is_op  1 = operator code in tok_data, 0 = operand value
//   tok_data   operand value or ASCII operator code (low 8 bits)
//
// Modports: master = token source, slave = evaluator.
interface rpn_if #(
    parameter int WIDTH = 8
);

    logic             tok_valid;
    logic             tok_ready;
    logic             tok_is_op;
    logic [WIDTH-1:0] tok_data;

    modport master (
        output tok_valid,
        output tok_is_op,
        output tok_data,
        input  tok_ready
    );

    modport slave (
        input  tok_valid,
        input  tok_is_op,
        input  tok_data,
        output tok_ready
    );

endinterface

// File: rtl/rpn_alu.sv
// rpn_alu: combinational arithmetic for the RPN evaluator.
//
// Ports:
//   a        deeper operand (left-hand side)
//   b        top-of-stack operand (right-hand side)
//   opcode   ASCII operator code
//   y        unsigned result, modulo 2^WIDTH
//   div_zero high when a division by zero is requested
//
// Configuration macro: RPN_DIV_EN builds the truncating unsigned divider;
// without it no divider logic exists and div_zero is tied low.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       opcode,
    output logic [WIDTH-1:0] y,
    output logic             div_zero
);

    // Select the operation; all results wrap to WIDTH bits, so the multiply
    // keeps only the low half of the full product.
    always_comb begin
        y        = '0;
        div_zero = 1'b0;
        case (opcode)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_MUL: y = a * b;
`ifdef RPN_DIV_EN
            OP_DIV: begin
                if (b == '0) begin
                    div_zero = 1'b1;
                end else begin
                    y = a / b;
                end
            end
`endif
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rpn_evaluator.sv
// rpn_evaluator: evaluates a reverse-Polish token stream against an
// externally attached operand stack.
//
// Ports:
//   clk, rst      clock (rising edge) and synchronous active-low reset
//   tok           token handshake (rpn_if slave)
//   stk_data_in   value to push onto the stack
//   stk_push_en   push strobe
//   stk_pop_en    pop strobe
//   stk_data_out  combinational top of stack
//   stk_empty     stack holds nothing
//   result        evaluated value (0 when the expression was in error)
//   result_err    expression was malformed or overflowed
//   result_valid  one-cycle pulse when result/result_err are updated
//   depth         current stack occupancy as tracked by the evaluator
//
// The stack must be reset in the same cycle as this block, using an
// inverted copy of rst for an active-high stack reset.
//
// Configuration macro: RPN_DIV_EN enables the '/' operator.
module rpn_evaluator
    import rpn_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_DEPTH = 100
) (
    input  logic             clk,
    input  logic             rst,
    rpn_if.slave             tok,
    output logic [WIDTH-1:0] stk_data_in,
    output logic             stk_push_en,
    output logic             stk_pop_en,
    input  logic [WIDTH-1:0] stk_data_out,
    input  logic             stk_empty,
    output logic [WIDTH-1:0] result,
    output logic             result_err,
    output logic             result_valid,
    output logic [7:0]       depth
);

    localparam logic [7:0] DEPTH_LIMIT = 8'(MAX_DEPTH);

    state_t           state_q, state_d;
    logic [7:0]       depth_q, depth_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [7:0]       opcode_q, opcode_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_err_q, result_err_d;

    logic             tok_ready_c;
    logic             push_c;
    logic             pop_c;
    logic             valid_c;
    logic [WIDTH-1:0] push_data_c;

    logic [WIDTH-1:0] alu_y;
    logic             alu_div_zero;

    rpn_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a        (a_q),
        .b        (b_q),
        .opcode   (opcode_q),
        .y        (alu_y),
        .div_zero (alu_div_zero)
    );

    // Next-state and stack-control logic. Every path into DRAIN other than
    // POP_RES has already raised the error flag, so flagging an error on
    // any pop inside DRAIN is exactly the "leftover operands" rule for the
    // '=' path and harmless elsewhere. POP_RES parks the final value in a_q,
    // which is free by then, and DRAIN copies it to the result registers on
    // the way into DONE so they are stable while result_valid is high.
    always_comb begin
        state_d      = state_q;
        depth_d      = depth_q;
        a_d          = a_q;
        b_d          = b_q;
        opcode_d     = opcode_q;
        err_d        = err_q;
        result_d     = result_q;
        result_err_d = result_err_q;
        tok_ready_c  = 1'b0;
        push_c       = 1'b0;
        pop_c        = 1'b0;
        valid_c      = 1'b0;
        push_data_c  = '0;

        case (state_q)
            IDLE: begin
                tok_ready_c = 1'b1;
                if (tok.tok_valid) begin
                    if (!tok.tok_is_op) begin
                        if (depth_q == DEPTH_LIMIT) begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            push_c      = 1'b1;
                            push_data_c = tok.tok_data;
                        end
                    end else if (is_arith_op(tok.tok_data[7:0])) begin
                        opcode_d = tok.tok_data[7:0];
                        state_d  = POP_B;
                    end else if (tok.tok_data[7:0] == OP_EQ) begin
                        state_d = POP_RES;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end

            POP_B: begin
                if (stk_empty) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    b_d     = stk_data_out;
                    pop_c   = 1'b1;
                    state_d = POP_A;
                end
            end

            POP_A: begin
                if (stk_empty) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    a_d     = stk_data_out;
                    pop_c   = 1'b1;
                    state_d = PUSH_R;
                end
            end

            PUSH_R: begin
                if (alu_div_zero) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    push_c      = 1'b1;
                    push_data_c = alu_y;
                    state_d     = IDLE;
                end
            end

            POP_RES: begin
                if (stk_empty) begin
                    err_d = 1'b1;
                end else begin
                    a_d   = stk_data_out;
                    pop_c = 1'b1;
                end
                state_d = DRAIN;
            end

            DRAIN: begin
                if (!stk_empty) begin
                    pop_c = 1'b1;
                    err_d = 1'b1;
                end else begin
                    result_d     = err_q ? '0 : a_q;
                    result_err_d = err_q;
                    state_d      = DONE;
                end
            end

            DONE: begin
                valid_c = 1'b1;
                err_d   = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is held nothing may touch the stack or be accepted,
        // even though the state register still shows the aborted operation.
        if (!rst) begin
            tok_ready_c = 1'b0;
            push_c      = 1'b0;
            pop_c       = 1'b0;
            valid_c     = 1'b0;
        end

        case ({push_c, pop_c})
            2'b10:   depth_d = depth_q + 8'd1;
            2'b01:   depth_d = depth_q - 8'd1;
            default: depth_d = depth_q;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            depth_q      <= 8'd0;
            a_q          <= '0;
            b_q          <= '0;
            opcode_q     <= 8'd0;
            err_q        <= 1'b0;
            result_q     <= '0;
            result_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            a_q          <= a_d;
            b_q          <= b_d;
            opcode_q     <= opcode_d;
            err_q        <= err_d;
            result_q     <= result_d;
            result_err_q <= result_err_d;
        end
    end

    assign tok.tok_ready  = tok_ready_c;
    assign stk_push_en    = push_c;
    assign stk_pop_en     = pop_c;
    assign stk_data_in    = push_data_c;
    assign result         = result_q;
    assign result_err     = result_err_q;
    assign result_valid   = valid_c;
    assign depth          = depth_q;

endmodule

// File: tb/tb_rpn_evaluator.sv
// tb_rpn_evaluator: directed token sequences with a result scoreboard.
// A behavioural operand stack is attached to the evaluator. Expected
// results are queued before each expression is sent; a monitor compares
// them whenever result_valid is seen.
module tb_rpn_evaluator;

    localparam int W    = 8;
    localparam int MAXD = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    rpn_if #(.WIDTH(W)) tok_bus ();

    logic [W-1:0] stk_data_in;
    logic         stk_push_en;
    logic         stk_pop_en;
    logic [W-1:0] stk_data_out;
    logic         stk_empty;
    logic [W-1:0] result;
    logic         result_err;
    logic         result_valid;
    logic [7:0]   depth;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    rpn_evaluator #(
        .WIDTH     (W),
        .MAX_DEPTH (MAXD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tok          (tok_bus),
        .stk_data_in  (stk_data_in),
        .stk_push_en  (stk_push_en),
        .stk_pop_en   (stk_pop_en),
        .stk_data_out (stk_data_out),
        .stk_empty    (stk_empty),
        .result       (result),
        .result_err   (result_err),
        .result_valid (result_valid),
        .depth        (depth)
    );

    // Behavioural operand stack, reset together with the evaluator.
    logic [W-1:0] stk_mem [0:127];
    int           stk_sp = 0;

    assign stk_empty    = (stk_sp == 0);
    assign stk_data_out = (stk_sp > 0) ? stk_mem[stk_sp-1] : '0;

    always @(posedge clk) begin
        if (!rst) begin
            stk_sp <= 0;
        end else if (stk_push_en && stk_sp < 128) begin
            stk_mem[stk_sp] <= stk_data_in;
            stk_sp          <= stk_sp + 1;
        end else if (stk_pop_en && stk_sp > 0) begin
            stk_sp <= stk_sp - 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectResult(input logic [7:0] res, input logic err);
        exp_t e;
        e.res = res;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Drive one token from a negedge; return at the negedge after transfer.
    task automatic applyStimulus(input logic is_op, input logic [7:0] data);
        int n;
        n = 0;
        tok_bus.tok_valid = 1'b1;
        tok_bus.tok_is_op = is_op;
        tok_bus.tok_data  = data;
        while (!tok_bus.tok_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!tok_bus.tok_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL token_accept_timeout: tok_ready 0 after %0d cycles, required 1", n);
        end
        @(negedge clk);
        tok_bus.tok_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: stack protocol sanity plus scoreboard compare on result_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (stk_push_en && stk_pop_en) begin
                errors++;
                $display("[TB] FAIL push_pop_overlap: push_en 1 pop_en 1, required not both");
            end
            if (stk_push_en && stk_sp >= MAXD) begin
                errors++;
                $display("[TB] FAIL push_past_capacity: push at occupancy %0d, required < %0d", stk_sp, MAXD);
            end
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got result 0x%0h err %0b, required no result",
                             result, result_err);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("result", 32'(result), 32'(e.res));
                    checkOutput("result_err", 32'(result_err), 32'(e.err));
                    checkOutput("depth_at_done", 32'(depth), 32'd0);
                end
            end
        end
    end

    initial begin
        int cnt;
        tok_bus.tok_valid = 1'b0;
        tok_bus.tok_is_op = 1'b0;
        tok_bus.tok_data  = 8'h00;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_depth", 32'(depth), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_result_err", 32'(result_err), 32'd0);
        checkOutput("reset_result_valid", 32'(result_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(tok_bus.tok_ready), 32'd1);

        // 3 4 + =  -> 0x07, with depth tracking and operator latency
        expectResult(8'h07, 1'b0);
        applyStimulus(1'b0, 8'd3);
        checkOutput("depth_one", 32'(depth), 32'd1);
        applyStimulus(1'b0, 8'd4);
        checkOutput("depth_two", 32'(depth), 32'd2);
        applyStimulus(1'b1, 8'h2B);
        cnt = 0;
        while (!tok_bus.tok_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("op_ready_latency", 32'(cnt + 1), 32'd4);
        checkOutput("depth_after_op", 32'(depth), 32'd1);
        applyStimulus(1'b1, 8'h3D);
        waitDrain();
        checkOutput("result_hold", 32'(result), 32'h07);

        // 5 9 - = -> 0xFC ; 20 13 * = -> 0x04 ; 200 100 + = -> 0x2C
        expectResult(8'hFC, 1'b0);
        applyStimulus(1'b0, 8'd5);
        applyStimulus(1'b0, 8'd9);
        applyStimulus(1'b1, 8'h2D);
        applyStimulus(1'b1, 8'h3D);
        expectResult(8'h04, 1'b0);
        applyStimulus(1'b0, 8'd20);
        applyStimulus(1'b0, 8'd13);
        applyStimulus(1'b1, 8'h2A);
        applyStimulus(1'b1, 8'h3D);
        expectResult(8'h2C, 1'b0);
        applyStimulus(1'b0, 8'd200);
        applyStimulus(1'b0, 8'd100);
        applyStimulus(1'b1, 8'h2B);
        applyStimulus(1'b1, 8'h3D);

        // 10 3 4 * - = -> 10 - 12 = 0xFE
        expectResult(8'hFE, 1'b0);
        applyStimulus(1'b0, 8'd10);
        applyStimulus(1'b0, 8'd3);
        applyStimulus(1'b0, 8'd4);
        applyStimulus(1'b1, 8'h2A);
        applyStimulus(1'b1, 8'h2D);
        applyStimulus(1'b1, 8'h3D);

        // 7 + -> underflow at POP_A
        expectResult(8'h00, 1'b1);
        applyStimulus(1'b0, 8'd7);
        applyStimulus(1'b1, 8'h2B);

        // 1 2 = -> leftover operand
        expectResult(8'h00, 1'b1);
        applyStimulus(1'b0, 8'd1);
        applyStimulus(1'b0, 8'd2);
        applyStimulus(1'b1, 8'h3D);

        // '#' on empty stack, then 6 '#' with a drained operand
        expectResult(8'h00, 1'b1);
        applyStimulus(1'b1, 8'h23);
        expectResult(8'h00, 1'b1);
        applyStimulus(1'b0, 8'd6);
        applyStimulus(1'b1, 8'h23);

        // '=' on empty stack
        expectResult(8'h00, 1'b1);
        applyStimulus(1'b1, 8'h3D);

        // recovery after errors: 2 3 * = -> 6
        expectResult(8'h06, 1'b0);
        applyStimulus(1'b0, 8'd2);
        applyStimulus(1'b0, 8'd3);
        applyStimulus(1'b1, 8'h2A);
        applyStimulus(1'b1, 8'h3D);
        waitDrain();

        // capacity: MAXD pushes fill the stack, one more overflows
        for (int i = 0; i < MAXD; i++) begin
            applyStimulus(1'b0, 8'(i + 1));
        end
        checkOutput("depth_full", 32'(depth), 32'(MAXD));
        expectResult(8'h00, 1'b1);
        applyStimulus(1'b0, 8'hAA);
        waitDrain();

`ifdef RPN_DIV_EN
        // 9 0 / -> divide by zero, then '=' alone on empty stack
        expectResult(8'h00, 1'b1);
        expectResult(8'h00, 1'b1);
        applyStimulus(1'b0, 8'd9);
        applyStimulus(1'b0, 8'd0);
        applyStimulus(1'b1, 8'h2F);
        applyStimulus(1'b1, 8'h3D);
        expectResult(8'h04, 1'b0);
        applyStimulus(1'b0, 8'd9);
        applyStimulus(1'b0, 8'd2);
        applyStimulus(1'b1, 8'h2F);
        applyStimulus(1'b1, 8'h3D);
`else
        // '/' unknown: error drains 9 and 2, then '=' alone on empty stack
        expectResult(8'h00, 1'b1);
        expectResult(8'h00, 1'b1);
        applyStimulus(1'b0, 8'd9);
        applyStimulus(1'b0, 8'd2);
        applyStimulus(1'b1, 8'h2F);
        applyStimulus(1'b1, 8'h3D);
`endif
        waitDrain();

        // reset while in PUSH_R aborts the push
        applyStimulus(1'b0, 8'd3);
        applyStimulus(1'b0, 8'd4);
        applyStimulus(1'b1, 8'h2B);
        @(negedge clk);
        @(negedge clk);
        checkOutput("push_r_push_en", 32'(stk_push_en), 32'd1);
        checkOutput("push_r_data", 32'(stk_data_in), 32'h07);
        rst = 1'b0;
        #1;
        checkOutput("abort_push_en", 32'(stk_push_en), 32'd0);
        checkOutput("abort_pop_en", 32'(stk_pop_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_depth", 32'(depth), 32'd0);
        checkOutput("abort_ready", 32'(tok_bus.tok_ready), 32'd1);
        checkOutput("abort_result_valid", 32'(result_valid), 32'd0);

        // 8 8 + = -> 0x10 after the abort
        @(negedge clk);
        expectResult(8'h10, 1'b0);
        applyStimulus(1'b0, 8'd8);
        applyStimulus(1'b0, 8'd8);
        applyStimulus(1'b1, 8'h2B);
        applyStimulus(1'b1, 8'h3D);
        waitDrain();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
